// File: rtl/enemy_motion_ctrl.sv
// ============================================================================
// Module   : enemy_motion_ctrl
// Purpose  : Per-enemy motion sequencer for the 32x32 enemy sprite. It holds
//            the top-left position and the one-hot facing direction, steps
//            once per video frame, turns on leading-edge wall hits and runs
//            the blink-then-dead sequence after an explosion hit.
// Options  : RANDOM_TURN_EN - when defined, an 8-bit LFSR picks clockwise,
//            counter-clockwise or reverse on each turn. When undefined, turns
//            are clockwise only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_motion_ctrl #(
  parameter logic [10:0] INIT_X       = 11'd64,
  parameter logic [10:0] INIT_Y       = 11'd64,
  parameter logic [3:0]  INIT_DIR     = 4'b1000,
  parameter logic [3:0]  SPEED        = 4'd1,
  parameter logic [10:0] X_MAX        = 11'd607,
  parameter logic [10:0] Y_MAX        = 11'd447,
  parameter logic [3:0]  TURN_FRAMES  = 4'd4,
  parameter logic [5:0]  DEATH_FRAMES = 6'd32
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        collision,
  input  logic [3:0]  HitEdgeCode,
  input  logic        explosionHit,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [3:0]  direction,
  output logic        visible,
  output logic        alive
);

  // One-hot direction codes, identical to the HitEdgeCode encoding.
  localparam logic [3:0] DIR_LEFT   = 4'b1000;
  localparam logic [3:0] DIR_TOP    = 4'b0100;
  localparam logic [3:0] DIR_RIGHT  = 4'b0010;
  localparam logic [3:0] DIR_BOTTOM = 4'b0001;

  localparam logic signed [11:0] X_MAX_S = {1'b0, X_MAX};
  localparam logic signed [11:0] Y_MAX_S = {1'b0, Y_MAX};
  localparam logic signed [11:0] SPEED_S = {8'd0, SPEED};

  typedef enum logic [1:0] {
    S_MOVE  = 2'd0,
    S_TURN  = 2'd1,
    S_DYING = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [3:0]  dir_q, dir_d;
  logic [3:0]  turn_cnt_q, turn_cnt_d;
  logic [5:0]  death_cnt_q, death_cnt_d;
  logic        wall_q, wall_d;
  logic        boom_q, boom_d;
  logic        visible_q, visible_d;
  logic        alive_q, alive_d;

  logic        w_step;
  logic        w_wall_evt;
  logic [3:0]  w_dir_cur;
  logic [3:0]  w_dir_turn;
  logic signed [11:0] w_nx, w_ny;
  logic [10:0] w_mx, w_my;
  logic        w_clamp;
  logic [3:0]  w_turn_next;
  logic [5:0]  w_death_next;

  assign w_step     = startOfFrame & enable;
  // Only a hit on the edge we are walking into counts as a wall.
  assign w_wall_evt = collision & (|(HitEdgeCode & dir_q));

  // Sanitise the direction: any non-one-hot value falls back to INIT_DIR.
  always_comb begin
    w_dir_cur = INIT_DIR;
    case (dir_q)
      DIR_LEFT, DIR_TOP, DIR_RIGHT, DIR_BOTTOM: w_dir_cur = dir_q;
      default:                                  w_dir_cur = INIT_DIR;
    endcase
  end

`ifdef RANDOM_TURN_EN
  logic [7:0] lfsr_q;

  // Free-running LFSR, taps for x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Pick the new heading; every option differs from the old one-hot value.
  always_comb begin
    w_dir_turn = {w_dir_cur[1:0], w_dir_cur[3:2]};
    case (lfsr_q[1:0])
      2'd0:    w_dir_turn = {w_dir_cur[0], w_dir_cur[3:1]};
      2'd1:    w_dir_turn = {w_dir_cur[2:0], w_dir_cur[3]};
      default: w_dir_turn = {w_dir_cur[1:0], w_dir_cur[3:2]};
    endcase
  end
`else
  // Clockwise: LEFT -> TOP -> RIGHT -> BOTTOM -> LEFT is a right rotate.
  always_comb begin
    w_dir_turn = {w_dir_cur[0], w_dir_cur[3:1]};
  end
`endif

  // Candidate move in 12-bit signed, clamped to the legal play area.
  always_comb begin
    w_nx    = {1'b0, x_q};
    w_ny    = {1'b0, y_q};
    w_clamp = 1'b0;
    case (w_dir_cur)
      DIR_LEFT:   w_nx = w_nx - SPEED_S;
      DIR_RIGHT:  w_nx = w_nx + SPEED_S;
      DIR_TOP:    w_ny = w_ny - SPEED_S;
      DIR_BOTTOM: w_ny = w_ny + SPEED_S;
      default:    w_nx = {1'b0, x_q};
    endcase
    w_mx = w_nx[10:0];
    w_my = w_ny[10:0];
    if (w_nx < 12'sd0) begin
      w_mx    = 11'd0;
      w_clamp = 1'b1;
    end else if (w_nx > X_MAX_S) begin
      w_mx    = X_MAX;
      w_clamp = 1'b1;
    end
    if (w_ny < 12'sd0) begin
      w_my    = 11'd0;
      w_clamp = 1'b1;
    end else if (w_ny > Y_MAX_S) begin
      w_my    = Y_MAX;
      w_clamp = 1'b1;
    end
  end

  assign w_turn_next  = turn_cnt_q + 4'd1;
  assign w_death_next = death_cnt_q + 6'd1;

  // Next-state logic: event latching every cycle, motion on frame steps.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    dir_d       = dir_q;
    turn_cnt_d  = turn_cnt_q;
    death_cnt_d = death_cnt_q;
    visible_d   = visible_q;
    alive_d     = alive_q;
    wall_d      = wall_q | w_wall_evt;
    boom_d      = boom_q | explosionHit;

    if (w_step) begin
      // Latches are consumed; an event arriving this cycle is kept.
      wall_d = w_wall_evt;
      boom_d = explosionHit;
      dir_d  = w_dir_cur;
      case (state_q)
        S_MOVE: begin
          if (boom_q) begin
            state_d     = S_DYING;
            alive_d     = 1'b0;
            visible_d   = 1'b1;
            death_cnt_d = 6'd0;
          end else if (wall_q) begin
            x_d        = prev_x_q;
            y_d        = prev_y_q;
            dir_d      = w_dir_turn;
            turn_cnt_d = 4'd0;
            state_d    = S_TURN;
          end else begin
            prev_x_d = x_q;
            prev_y_d = y_q;
            x_d      = w_mx;
            y_d      = w_my;
            if (w_clamp) wall_d = 1'b1;
          end
        end
        S_TURN: begin
          if (boom_q) begin
            state_d     = S_DYING;
            alive_d     = 1'b0;
            visible_d   = 1'b1;
            death_cnt_d = 6'd0;
          end else begin
            turn_cnt_d = w_turn_next;
            if (w_turn_next >= TURN_FRAMES - 4'd1) state_d = S_MOVE;
          end
        end
        S_DYING: begin
          if (death_cnt_q == DEATH_FRAMES - 6'd1) begin
            state_d   = S_DEAD;
            visible_d = 1'b0;
          end else begin
            death_cnt_d = w_death_next;
            visible_d   = ~w_death_next[2];
          end
        end
        default: begin
          visible_d = 1'b0;
          alive_d   = 1'b0;
        end
      endcase
    end

    // A dead enemy no longer reacts to anything.
    if (state_q == S_DEAD) begin
      wall_d = 1'b0;
      boom_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_MOVE;
      x_q         <= INIT_X;
      y_q         <= INIT_Y;
      prev_x_q    <= INIT_X;
      prev_y_q    <= INIT_Y;
      dir_q       <= INIT_DIR;
      turn_cnt_q  <= 4'd0;
      death_cnt_q <= 6'd0;
      wall_q      <= 1'b0;
      boom_q      <= 1'b0;
      visible_q   <= 1'b1;
      alive_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      dir_q       <= dir_d;
      turn_cnt_q  <= turn_cnt_d;
      death_cnt_q <= death_cnt_d;
      wall_q      <= wall_d;
      boom_q      <= boom_d;
      visible_q   <= visible_d;
      alive_q     <= alive_d;
    end
  end

  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign direction = dir_q;
  assign visible   = visible_q;
  assign alive     = alive_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_motion_ctrl.sv
// ============================================================================
// Module   : tb_enemy_motion_ctrl
// Purpose  : Scoreboard bench for enemy_motion_ctrl. Each frame pulse pushes
//            its hand-computed expected outputs; a monitor pops and compares
//            one cycle-edge later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_motion_ctrl;

  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] T = 4'b0100;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] B = 4'b0001;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        enable;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic        explosionHit;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [3:0]  direction;
  logic        visible;
  logic        alive;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  d;
    logic        v;
    logic        a;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   failed;
  int   frame_idx;

  enemy_motion_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .collision    (collision),
    .HitEdgeCode  (HitEdgeCode),
    .explosionHit (explosionHit),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .direction    (direction),
    .visible      (visible),
    .alive        (alive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every frame pulse produces one observable result after the edge.
  always @(posedge clk) begin
    exp_t e;
    exp_t got;
    if (startOfFrame) begin
      #1;
      got = '{x: topLeftX, y: topLeftY, d: direction, v: visible, a: alive};
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL frame%0d: unexpected output x=%0d y=%0d dir=%b vis=%b alive=%b, none required",
                 frame_idx, got.x, got.y, got.d, got.v, got.a);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL frame%0d: got x=%0d y=%0d dir=%b vis=%b alive=%b, want x=%0d y=%0d dir=%b vis=%b alive=%b",
                   frame_idx, got.x, got.y, got.d, got.v, got.a, e.x, e.y, e.d, e.v, e.a);
        end
      end
      frame_idx++;
    end
  end

  task automatic frame(input logic [10:0] x, input logic [10:0] y,
                       input logic [3:0] d, input logic v, input logic a);
    @(negedge clk);
    exp_q.push_back('{x: x, y: y, d: d, v: v, a: a});
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic hit(input logic [3:0] code, input logic boom);
    @(negedge clk);
    collision    = (code != 4'd0);
    HitEdgeCode  = code;
    explosionHit = boom;
    @(negedge clk);
    collision    = 1'b0;
    HitEdgeCode  = 4'd0;
    explosionHit = 1'b0;
  endtask

  // Direct check of the asynchronous reset values, taken while reset is low.
  task automatic chk_reset(input string name);
    #1;
    tests++;
    if ({topLeftX, topLeftY, direction, visible, alive} !==
        {11'd64, 11'd64, L, 1'b1, 1'b1}) begin
      failed++;
      $display("FAIL %s: got x=%0d y=%0d dir=%b vis=%b alive=%b, want x=64 y=64 dir=1000 vis=1 alive=1",
               name, topLeftX, topLeftY, direction, visible, alive);
    end
  endtask

  initial begin
    logic [10:0] xs;
    tests        = 0;
    failed       = 0;
    frame_idx    = 0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    enable       = 1'b1;
    collision    = 1'b0;
    HitEdgeCode  = 4'd0;
    explosionHit = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset_init");
    @(negedge clk);
    resetN = 1'b1;

    // Free motion to the left.
    frame(63, 64, L, 1, 1);
    frame(62, 64, L, 1, 1);
    frame(61, 64, L, 1, 1);

    // Side and rear hits do not turn the enemy.
    hit(B, 1'b0);
    hit(R, 1'b0);
    frame(60, 64, L, 1, 1);

    // Leading-edge hit: revert to previous position, turn to TOP, hold.
    hit(L, 1'b0);
    frame(61, 64, T, 1, 1);
    repeat (3) frame(61, 64, T, 1, 1);
    frame(61, 63, T, 1, 1);
    frame(61, 62, T, 1, 1);

    // Latched hit while frozen: pulses do nothing until enable returns.
    hit(T, 1'b0);
    enable = 1'b0;
    repeat (5) frame(61, 62, T, 1, 1);
    enable = 1'b1;
    frame(61, 63, R, 1, 1);
    repeat (3) frame(61, 63, R, 1, 1);
    frame(62, 63, R, 1, 1);
    frame(63, 63, R, 1, 1);

    // Asynchronous reset in the middle of a frame period.
    @(negedge clk);
    resetN = 1'b0;
    chk_reset("reset_async");
    @(negedge clk);
    resetN = 1'b1;

    // Walk to the left boundary, then clamp and turn.
    for (int i = 1; i <= 64; i++) begin
      xs = 11'(64 - i);
      frame(xs, 64, L, 1, 1);
    end
    frame(0, 64, L, 1, 1);
    frame(0, 64, T, 1, 1);
    repeat (3) frame(0, 64, T, 1, 1);
    frame(0, 63, T, 1, 1);
    frame(0, 62, T, 1, 1);

    // Explosion together with a wall hit: dying wins, position frozen.
    hit(T, 1'b1);
    frame(0, 62, T, 1, 0);
    for (int k = 1; k < 32; k++) begin
      frame(0, 62, T, ~k[2], 0);
    end
    frame(0, 62, T, 0, 0);
    hit(L, 1'b1);
    frame(0, 62, T, 0, 0);
    frame(0, 62, T, 0, 0);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
